// File: rtl/step_period_meter.sv
// Step pulse period meter: synchronizes a step/dir pulse train, measures edge-to-edge
// spacing in clk cycles, tracks signed position and flags stalls and too-close edges.
module step_period_meter #(
  parameter int unsigned TIMEOUT    = 131071,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drv_step,
  input  logic        drv_dir,
  input  logic        drv_enable_SM,
  input  logic        clr,
  output logic [16:0] period,
  output logic        period_valid,
  output logic [31:0] position,
  output logic        stall,
  output logic        err
);

  localparam int unsigned CNT_W = 17;
  localparam int unsigned POS_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE, STALL} state_t;

  logic [2:0]       step_sync;
  logic [1:0]       dir_sync;
  logic             filled;
  logic             armed;
  logic             step_edge;
  logic             dir_now;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             valid_nxt;
  logic [POS_W-1:0] position_nxt;
  logic             stall_nxt;
  logic             err_nxt;
  logic             accept;

  // Synchronizers; armed only after a genuine low sample so a pulse held across reset is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync <= '0;
      dir_sync  <= '0;
      filled    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      step_sync <= {step_sync[1:0], drv_step};
      dir_sync  <= {dir_sync[0], drv_dir};
      filled    <= 1'b1;
      armed     <= armed | (filled & ~step_sync[0]);
    end
  end

  assign step_edge = step_sync[1] & ~step_sync[2] & armed;
  assign dir_now   = dir_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      position     <= '0;
      stall        <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      period       <= period_nxt;
      period_valid <= valid_nxt;
      position     <= position_nxt;
      stall        <= stall_nxt;
      err          <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    period_nxt   = period;
    valid_nxt    = 1'b0;
    position_nxt = position;
    stall_nxt    = stall;
    err_nxt      = err;
    accept       = 1'b0;

    if (!drv_enable_SM) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      period_nxt = '0;
      stall_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt    = '0;
          period_nxt = '0;
          stall_nxt  = 1'b0;
          state_nxt  = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (step_edge) begin
            state_nxt = MEASURE;
            cnt_nxt   = CNT_W'(1);
            accept    = 1'b1;
          end
        end
        MEASURE: begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          // An edge always takes priority over the timeout in the same cycle
          if (step_edge && cnt >= MIN_CNT) begin
            period_nxt = cnt;
            valid_nxt  = 1'b1;
            cnt_nxt    = CNT_W'(1);
            accept     = 1'b1;
          end else if (step_edge) begin
            err_nxt = 1'b1;
          end else if (cnt >= TO_CNT) begin
            state_nxt  = STALL;
            stall_nxt  = 1'b1;
            period_nxt = '0;
            valid_nxt  = 1'b1;
          end
        end
        STALL: begin
          if (step_edge) begin
            state_nxt = MEASURE;
            stall_nxt = 1'b0;
            cnt_nxt   = CNT_W'(1);
            accept    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (accept) begin
      position_nxt = dir_now ? position + POS_W'(1) : position - POS_W'(1);
    end

    if (clr) begin
      position_nxt = '0;
      err_nxt      = 1'b0;
    end
  end

endmodule

// File: tb/tb_step_period_meter.sv
// Scoreboard bench for step_period_meter: expected periods are queued as pulses are
// driven and matched against every period_valid strobe.
module tb_step_period_meter;

  localparam int unsigned TO = 50;
  localparam int unsigned MP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_step;
  logic        drv_dir;
  logic        drv_enable_SM;
  logic        clr;
  logic [16:0] period;
  logic        period_valid;
  logic [31:0] position;
  logic        stall;
  logic        err;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_q[$];
  logic [16:0] exp_p;

  step_period_meter #(.TIMEOUT(TO), .MIN_PERIOD(MP)) dut (
    .clk(clk), .rst(rst), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_SM(drv_enable_SM), .clr(clr), .period(period),
    .period_valid(period_valid), .position(position), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  // Every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got period=%0d, required no strobe", period);
      end else begin
        exp_p = exp_q.pop_front();
        if (period !== exp_p) begin
          errors++;
          $display("FAIL strobe_period: got %0d, required %0d", period, exp_p);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; drv_step = 1'b0; drv_dir = 1'b1; clr = 1'b0; drv_enable_SM = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic step_pulse(input logic d, input int gap);
    drv_dir = d; drv_step = 1'b1;
    @(negedge clk);
    drv_step = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; drv_step = 1'b0; drv_dir = 1'b1; clr = 1'b0; drv_enable_SM = 1'b1;
    @(negedge clk);
    checks++;
    if ({period, period_valid, stall, err} !== 20'd0) begin
      errors++; $display("FAIL reset_flags: got %h, required 0", {period, period_valid, stall, err});
    end
    checks++;
    if (position !== 32'd0) begin
      errors++; $display("FAIL reset_position: got %h, required 0", position);
    end
  endtask

  task automatic test_reset_mid_pulse();
    rst = 1'b1; drv_step = 1'b1; drv_enable_SM = 1'b1; exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (position !== 32'd0) begin
      errors++; $display("FAIL held_pulse_ignored: got position %h, required 0", position);
    end
    drv_step = 1'b0;
    @(negedge clk);
    step_pulse(1'b1, 6);
    checks++;
    if (position !== 32'd1) begin
      errors++; $display("FAIL first_edge_after_low: got position %h, required 1", position);
    end
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) exp_q.push_back(17'd10);
      step_pulse(1'b1, 10);
    end
    checks++;
    if (position !== 32'd6) begin
      errors++; $display("FAIL fwd_position: got %h, required 6", position);
    end
    checks++;
    if (period !== 17'd10) begin
      errors++; $display("FAIL fwd_period: got %0d, required 10", period);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL fwd_strobes: %0d strobes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_reverse();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) exp_q.push_back(17'd20);
      step_pulse((i == 3) ? 1'b1 : 1'b0, 20);
    end
    checks++;
    if (position !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL rev_position: got %h, required fffffffe", position);
    end
    checks++;
    if (period !== 17'd20 || exp_q.size() != 0) begin
      errors++; $display("FAIL rev_period: got %0d (pending %0d), required 20 (pending 0)", period, exp_q.size());
    end
  endtask

  task automatic test_min_period();
    do_reset();
    exp_q.push_back(17'd10);
    exp_q.push_back(17'd10);
    step_pulse(1'b1, 10);
    step_pulse(1'b1, 2);
    step_pulse(1'b1, 8);
    step_pulse(1'b1, 10);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL minp_err: got %b, required 1", err);
    end
    checks++;
    if (position !== 32'd3 || period !== 17'd10) begin
      errors++; $display("FAIL minp_pos_period: got pos %h period %0d, required 3 and 10", position, period);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (err !== 1'b0 || position !== 32'd0) begin
      errors++; $display("FAIL minp_clr: got err %b pos %h, required 0 and 0", err, position);
    end
    checks++;
    if (period !== 17'd10 || exp_q.size() != 0) begin
      errors++; $display("FAIL minp_clr_period: got %0d (pending %0d), required 10 (pending 0)", period, exp_q.size());
    end
  endtask

  task automatic test_min_boundary();
    do_reset();
    exp_q.push_back(17'd4);
    exp_q.push_back(17'd8);
    step_pulse(1'b1, 4);
    step_pulse(1'b1, 3);
    step_pulse(1'b1, 5);
    step_pulse(1'b1, 6);
    checks++;
    if (err !== 1'b1 || position !== 32'd3) begin
      errors++; $display("FAIL bound_err_pos: got err %b pos %h, required 1 and 3", err, position);
    end
    checks++;
    if (period !== 17'd8 || exp_q.size() != 0) begin
      errors++; $display("FAIL bound_period: got %0d (pending %0d), required 8 (pending 0)", period, exp_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back(17'd0);
    drv_dir = 1'b1; drv_step = 1'b1;
    @(negedge clk);
    drv_step = 1'b0;
    repeat (51) @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_early: got %b, required 0", stall);
    end
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || period !== 17'd0) begin
      errors++; $display("FAIL stall_set: got stall %b period %0d, required 1 and 0", stall, period);
    end
    step_pulse(1'b1, 8);
    checks++;
    if (stall !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_exit: got stall %b (pending %0d), required 0 (pending 0)", stall, exp_q.size());
    end
    exp_q.push_back(17'd8);
    step_pulse(1'b1, 8);
    checks++;
    if (period !== 17'd8 || position !== 32'd3) begin
      errors++; $display("FAIL stall_resume: got period %0d pos %h, required 8 and 3", period, position);
    end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    exp_q.push_back(17'd50);
    step_pulse(1'b1, 50);
    step_pulse(1'b1, 6);
    checks++;
    if (stall !== 1'b0 || period !== 17'd50) begin
      errors++; $display("FAIL to_edge: got stall %b period %0d, required 0 and 50", stall, period);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL to_edge_strobes: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.position_nxt = 32'h7FFF_FFFF;
    @(negedge clk);
    release dut.position_nxt;
    checks++;
    if (position !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL wrap_preload: got %h, required 7fffffff", position);
    end
    step_pulse(1'b1, 6);
    checks++;
    if (position !== 32'h8000_0000) begin
      errors++; $display("FAIL wrap_up: got %h, required 80000000", position);
    end
    exp_q.push_back(17'd6);
    step_pulse(1'b0, 6);
    checks++;
    if (position !== 32'h7FFF_FFFF || exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_down: got %h (pending %0d), required 7fffffff (pending 0)", position, exp_q.size());
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) exp_q.push_back(17'd10);
      step_pulse(1'b1, 10);
    end
    checks++;
    if (period !== 17'd10 || position !== 32'd7) begin
      errors++; $display("FAIL pre_rst: got period %0d pos %h, required 10 and 7", period, position);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({period, period_valid, stall, err} !== 20'd0 || position !== 32'd0) begin
      errors++; $display("FAIL async_rst: got %h pos %h, required 0 and 0", {period, period_valid, stall, err}, position);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable_low();
    do_reset();
    exp_q.push_back(17'd10);
    exp_q.push_back(17'd10);
    for (int i = 0; i < 3; i++) step_pulse(1'b1, 10);
    drv_enable_SM = 1'b0;
    @(negedge clk);
    checks++;
    if (period !== 17'd0 || stall !== 1'b0 || position !== 32'd3) begin
      errors++; $display("FAIL en_low: got period %0d stall %b pos %h, required 0, 0, 3", period, stall, position);
    end
    step_pulse(1'b1, 10);
    checks++;
    if (position !== 32'd3 || exp_q.size() != 0) begin
      errors++; $display("FAIL en_low_ignore: got pos %h (pending %0d), required 3 (pending 0)", position, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_pulse();
    test_forward();
    test_reverse();
    test_min_period();
    test_min_boundary();
    test_stall();
    test_timeout_edge();
    test_wrap();
    test_back_to_back_reset();
    test_enable_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
